// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller for sync_fifo: credit-limited FIFO reads into a circular output buffer
// presented as a valid/ready stream. Optional read-return watchdog under SYNC_FIFO_RD_TIMEOUT_EN.
module sync_fifo_rd_ctrl #(
  parameter int DATA_W      = 32,
  parameter int OBUF_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              hw_rst,
  input  logic              sw_rst,
  input  logic              enable,
  input  logic              flush,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              flush_done,
  output logic [31:0]       rd_count,
  output logic              err_unexp_vld,
  output logic              timeout_err
);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic              rst;
  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     occ, outst;
  logic              vld_ok, push, pop, flush_done_nxt, to_hit;

  assign rst = hw_rst | sw_rst;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both buffered and in-flight words, so a return always has a free slot.
  assign fifo_rd_en = (state == RUN) && !fifo_empty &&
                      (({1'b0, occ} + {1'b0, outst}) < (CW+1)'(OBUF_DEPTH));
  assign vld_ok  = fifo_valid && (outst != '0);
  assign push    = vld_ok && (state != FLUSH);
  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != '0);
  assign m_data  = mem[head];

  always_comb begin
    state_nxt      = state;
    flush_done_nxt = 1'b0;
    case (state)
      IDLE:    if (flush) state_nxt = FLUSH; else if (enable) state_nxt = RUN;
      RUN:     if (flush) state_nxt = FLUSH; else if (!enable) state_nxt = IDLE;
      FLUSH:   if (outst == '0) begin state_nxt = IDLE; flush_done_nxt = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flush_done    <= 1'b0;
      rd_count      <= '0;
      err_unexp_vld <= 1'b0;
      outst         <= '0;
      occ           <= '0;
      head          <= '0;
      tail          <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nxt;
      flush_done <= flush_done_nxt;
      if (fifo_valid && outst == '0) err_unexp_vld <= 1'b1;
      if (pop) rd_count <= rd_count + 32'd1;
      if (to_hit)                  outst <= '0;
      else if (fifo_rd_en && !vld_ok) outst <= outst + 1'b1;
      else if (!fifo_rd_en && vld_ok) outst <= outst - 1'b1;
      // Anything pushed or popped on the flush cycle is discarded along with the rest.
      if (state_nxt == FLUSH) begin
        occ  <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          mem[tail] <= fifo_rd_data;
          tail      <= nxt_ptr(tail);
        end
        if (pop) head <= nxt_ptr(head);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef SYNC_FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
  logic          to_err;

  assign to_hit      = (outst != '0) && !fifo_valid && (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = to_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      to_err   <= 1'b0;
    end else begin
      if (outst == '0 || fifo_valid || to_hit) wait_cnt <= '0;
      else                                      wait_cnt <= wait_cnt + 1'b1;
      if (to_hit) to_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
